multicycle_cpu: RTL and testbench

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/multicycle_cpu.sv | 151 +++++++++++++++
 tb/tb_multicycle_cpu.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_cpu.sv
// rtl/multicycle_cpu.sv - multicycle CPU (FETCH/DECODE/EXEC/WB, CPI 3-4, HALT on 16'hFFFF)
// Optional beq/bne support is compiled in with MULTICYCLE_CPU_BRANCH_EN.
module multicycle_cpu #(
   parameter int WIDTH   = 16,
   parameter int IMEM_AW = 10
) (
   input  logic               clock,
   input  logic               reset,
   output logic [IMEM_AW-1:0] imem_addr,
   input  logic [15:0]        imem_rdata,
   output logic [15:0]        PC,
   output logic [15:0]        IR,
   output logic [WIDTH-1:0]   ALUOut,
   output logic               zero,
   output logic [2:0]         state,
   output logic               halted,
   output logic [15:0]        retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_WB     = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [15:0]      r_pc;
   logic [15:0]      r_ir;
   logic [15:0]      r_retired;
   logic [WIDTH-1:0] r_aluout;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_regs [4];

   logic [3:0]       w_op;
   logic [1:0]       w_dec_rs;
   logic [1:0]       w_dec_rt;
   logic [1:0]       w_dst;
   logic [WIDTH-1:0] w_rs_val;
   logic [WIDTH-1:0] w_rt_val;
   logic [WIDTH-1:0] w_imm_ext;
   logic [WIDTH-1:0] w_alu;
   logic             w_is_alu;
   logic             w_slt;
   logic             w_taken;
   logic [15:0]      w_pc_inc;
   logic [15:0]      w_pc_exec;

   assign imem_addr = r_pc[IMEM_AW:1];
   assign PC        = r_pc;
   assign IR        = r_ir;
   assign ALUOut    = r_aluout;
   assign zero      = (r_aluout == '0);
   assign state     = r_state;
   assign halted    = (r_state == S_HALT);
   assign retired   = r_retired;

   // Operand addresses come straight from the memory word while DECODE latches it.
   assign w_dec_rs  = imem_rdata[11:10];
   assign w_dec_rt  = imem_rdata[9:8];
   assign w_rs_val  = (w_dec_rs == 2'd0) ? '0 : r_regs[w_dec_rs];
   assign w_rt_val  = (w_dec_rt == 2'd0) ? '0 : r_regs[w_dec_rt];

   assign w_op      = r_ir[15:12];
   assign w_is_alu  = ~r_ir[15];
   assign w_dst     = (w_op == 4'd7) ? r_ir[9:8] : r_ir[7:6];
   assign w_imm_ext = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
   assign w_slt     = ($signed(r_a) < $signed(r_b));
   assign w_pc_inc  = r_pc + 16'd2;

`ifdef MULTICYCLE_CPU_BRANCH_EN
   logic [15:0] w_imm16;
   logic [15:0] w_br_off;
   assign w_imm16   = {{8{r_ir[7]}}, r_ir[7:0]};
   assign w_br_off  = w_imm16 << 1;
   assign w_taken   = ((w_op == 4'b1000) && (r_a == r_b)) ||
                      ((w_op == 4'b1001) && (r_a != r_b));
   assign w_pc_exec = w_taken ? (w_pc_inc + w_br_off) : w_pc_inc;
`else
   assign w_taken   = 1'b0;
   assign w_pc_exec = w_pc_inc;
`endif

   always_comb begin
      w_alu = '0;
      case (w_op)
         4'd0:    w_alu = r_a + r_b;
         4'd1:    w_alu = r_a - r_b;
         4'd2:    w_alu = r_a & r_b;
         4'd3:    w_alu = r_a | r_b;
         4'd4:    w_alu = ~(r_a | r_b);
         4'd5:    w_alu = ~(r_a & r_b);
         4'd6:    w_alu = {{(WIDTH-1){1'b0}}, w_slt};
         4'd7:    w_alu = r_a + w_imm_ext;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_FETCH:  w_next_state = S_DECODE;
         S_DECODE: w_next_state = (imem_rdata == 16'hFFFF) ? S_HALT : S_EXEC;
         S_EXEC:   w_next_state = w_is_alu ? S_WB : S_FETCH;
         S_WB:     w_next_state = S_FETCH;
         S_HALT:   w_next_state = S_HALT;
         default:  w_next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state   <= S_FETCH;
         r_pc      <= '0;
         r_ir      <= '0;
         r_retired <= '0;
         r_aluout  <= '0;
         r_a       <= '0;
         r_b       <= '0;
         for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      end else begin
         r_state <= w_next_state;
         case (r_state)
            S_DECODE: begin
               r_ir <= imem_rdata;
               r_a  <= w_rs_val;
               r_b  <= w_rt_val;
            end
            S_EXEC: begin
               // Non-ALU ops (branches and NOPs) retire here and leave ALUOut alone.
               if (w_is_alu) begin
                  r_aluout <= w_alu;
               end else begin
                  r_pc      <= w_pc_exec;
                  r_retired <= r_retired + 16'd1;
               end
            end
            S_WB: begin
               if (w_dst != 2'd0) r_regs[w_dst] <= r_aluout;
               r_pc      <= w_pc_inc;
               r_retired <= r_retired + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb/tb_multicycle_cpu.sv - instruction-level model expanded into per-cycle expectations for multicycle_cpu
module tb_multicycle_cpu;

   localparam int WIDTH   = 16;
   localparam int IMEM_AW = 10;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [IMEM_AW-1:0] imem_addr;
   logic [15:0]        imem_rdata;
   logic [15:0]        PC;
   logic [15:0]        IR;
   logic [WIDTH-1:0]   ALUOut;
   logic               zero;
   logic [2:0]         state;
   logic               halted;
   logic [15:0]        retired;

   multicycle_cpu #(.WIDTH(WIDTH), .IMEM_AW(IMEM_AW)) dut (
      .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .PC(PC), .IR(IR), .ALUOut(ALUOut), .zero(zero), .state(state),
      .halted(halted), .retired(retired)
   );

   always #5 clock = ~clock;

   logic [15:0] mem [0:(1<<IMEM_AW)-1];
   always @(posedge clock) imem_rdata <= mem[imem_addr];

   typedef struct packed {
      logic [2:0]             st;
      logic [15:0]            pc;
      logic [15:0]            ir;
      logic [WIDTH-1:0]       alu;
      logic [15:0]            ret;
      logic [3:0][WIDTH-1:0]  regs;
   } rec_t;

   rec_t                  q[$];
   rec_t                  last;
   logic [15:0]           prog[$];
   int                    checks = 0;
   int                    errors = 0;
   logic [15:0]           m_pc, m_ir, m_ret;
   logic [WIDTH-1:0]      m_alu;
   logic [3:0][WIDTH-1:0] m_regs;
   logic                  m_halted;

`ifdef MULTICYCLE_CPU_BRANCH_EN
   localparam logic [15:0] BR_TAKEN_PC = 16'd10;
`else
   localparam logic [15:0] BR_TAKEN_PC = 16'd6;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void push(input logic [2:0] st);
      rec_t r;
      r.st = st; r.pc = m_pc; r.ir = m_ir; r.alu = m_alu; r.ret = m_ret; r.regs = m_regs;
      q.push_back(r);
   endfunction

   // Executes one instruction of the architectural model and queues the cycles it occupies.
   task automatic expand();
      logic [15:0]      w, npc;
      logic [3:0]       op;
      logic [1:0]       dst;
      logic [WIDTH-1:0] a, b, imm, res;
      if (m_halted) begin
         push(3'd4);
         return;
      end
      push(3'd0);
      push(3'd1);
      w = mem[m_pc[IMEM_AW:1]];
      m_ir = w;
      if (w == 16'hFFFF) begin
         m_halted = 1'b1;
         push(3'd4);
         return;
      end
      push(3'd2);
      op  = w[15:12];
      a   = m_regs[w[11:10]];
      b   = m_regs[w[9:8]];
      imm = WIDTH'(w[7:0]) - (w[7] ? WIDTH'(256) : WIDTH'(0));
      npc = m_pc + 16'd2;
      if (op <= 4'd7) begin
         case (op)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = ~(a | b);
            4'd5:    res = ~(a & b);
            4'd6:    res = (a[WIDTH-1] != b[WIDTH-1]) ? WIDTH'(a[WIDTH-1]) : WIDTH'(a < b);
            default: res = a + imm;
         endcase
         m_alu = res;
         push(3'd3);
         dst = (op == 4'd7) ? w[9:8] : w[7:6];
         if (dst != 2'd0) m_regs[dst] = res;
      end else begin
`ifdef MULTICYCLE_CPU_BRANCH_EN
         if ((op == 4'd8 && a == b) || (op == 4'd9 && a != b)) begin
            int off;
            off = int'(w[7:0]);
            if (w[7]) off = off - 256;
            npc = npc + 16'(off * 2);
         end
`endif
      end
      m_pc  = npc;
      m_ret = m_ret + 16'd1;
   endtask

   task automatic check_cycle();
      rec_t e;
      if (q.size() == 0) expand();
      e = q.pop_front();
      last = e;
      chk("state", state, e.st);
      chk("pc", PC, e.pc);
      chk("ir", IR, e.ir);
      chk("aluout", ALUOut, e.alu);
      chk("zero", zero, (e.alu == '0));
      chk("halted", halted, (e.st == 3'd4));
      chk("retired", retired, e.ret);
      chk("imem_addr", imem_addr, e.pc[IMEM_AW:1]);
      for (int i = 0; i < 4; i++) chk($sformatf("r%0d", i), dut.r_regs[i], e.regs[i]);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
      check_cycle();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      q.delete();
      m_pc = '0; m_ir = '0; m_alu = '0; m_ret = '0; m_regs = '0; m_halted = 1'b0;
      check_cycle();
   endtask

   task automatic load_prog();
      for (int i = 0; i < (1 << IMEM_AW); i++) mem[i] = 16'hFFFF;
      foreach (prog[i]) mem[i] = prog[i];
   endtask

   initial begin
      // Main program: addi, sub, slt both ways, logic ops, r0 target, NOPs, wrapping addi, halt at 32.
      prog = '{16'h710F, 16'h7207, 16'h19C0, 16'h6B40, 16'h6E80, 16'h7155, 16'h73F0, 16'h2780,
               16'h3740, 16'h4B80, 16'h56C0, 16'h0100, 16'h0000, 16'hA123, 16'h8602, 16'h757F,
               16'hFFFF};
      load_prog();
      do_reset();
      chk("lit_reset_pc", PC, 16'd0);
      chk("lit_reset_zero", zero, 1'b1);
      run(3);
      chk("lit_wb_state", state, 3'd3);
      chk("lit_wb_addi", ALUOut, 16'd15);
      run(5);
      chk("lit_pc_after2", PC, 16'd4);
      chk("lit_retired_after2", retired, 16'd2);
      chk("lit_r1", dut.r_regs[1], 16'd15);
      chk("lit_r2", dut.r_regs[2], 16'd7);
      run(3);
      chk("lit_sub", ALUOut, 16'hFFF8);
      run(5);
      chk("lit_slt_r1", dut.r_regs[1], 16'd0);
      run(70);
      chk("lit_halted", halted, 1'b1);
      run(20);
      chk("lit_halt_pc", PC, 16'd32);
      chk("lit_halt_retired", retired, 16'd16);

      // Equal operands: beq taken when compiled in, NOP otherwise.
      prog = '{16'h7105, 16'h7205, 16'h8602, 16'hFFFF, 16'hFFFF, 16'h9602, 16'hFFFF};
      load_prog();
      do_reset();
      chk("lit_reset_halted", halted, 1'b0);
      run(11);
      chk("lit_beq_pc", PC, BR_TAKEN_PC);
      chk("lit_beq_retired", retired, 16'd3);
      run(20);

      // Unequal operands: falls through into the halt at PC 6.
      prog = '{16'h7105, 16'h7206, 16'h8602, 16'hFFFF};
      load_prog();
      do_reset();
      run(11);
      chk("lit_bne_pc", PC, 16'd6);
      run(2);
      chk("lit_halt_state", state, 3'd4);
      run(20);
      chk("lit_halt6_pc", PC, 16'd6);
      chk("lit_halt6_retired", retired, 16'd3);
      do_reset();
      chk("lit_exit_halt_pc", PC, 16'd0);
      chk("lit_exit_halt", halted, 1'b0);

      // Reset landing on the WB edge of the first addi.
      prog = '{16'h710F, 16'h7207, 16'hFFFF};
      load_prog();
      do_reset();
      for (int i = 0; i < 8 && last.st != 3'd3; i++) tick();
      chk("reached_wb", last.st, 3'd3);
      do_reset();
      chk("lit_wbreset_r1", dut.r_regs[1], 16'd0);
      chk("lit_wbreset_retired", retired, 16'd0);
      chk("lit_wbreset_state", state, 3'd0);
      run(10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
